// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and fetch-address outputs of the PC sequencer
interface pc_sequencer_if #(parameter int COUNT_WIDTH = 16);
  logic stall;
  logic branch_taken;
  logic [31:0] branch_target;
  logic halt_req;
  logic resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic valid;
  logic halted;
  logic fault;
  logic [COUNT_WIDTH-1:0] fetch_count;
  modport master (
    output stall, branch_taken, branch_target, halt_req, resume,
    input  pc, pc_plus4, valid, halted, fault, fetch_count
  );
  modport slave (
    input  stall, branch_taken, branch_target, halt_req, resume,
    output pc, pc_plus4, valid, halted, fault, fetch_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: KGP-RISC fetch PC with advance/redirect/stall/halt; PC_ALIGN_CHECK_EN adds a misaligned-target FAULT state
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int COUNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  pc_sequencer_if.slave bus
);
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;
  logic [1:0] state, state_n;
  logic [31:0] pc, tgt;
  logic [COUNT_WIDTH-1:0] cnt;
  logic misaligned, redirect, take, to_fault, adv;
`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = |bus.branch_target[1:0];
  assign tgt = bus.branch_target;
  assign bus.fault = state == FAULT;
`else
  assign misaligned = 1'b0;
  assign tgt = {bus.branch_target[31:2], 2'b00};
  assign bus.fault = 1'b0;
`endif
  always_comb begin
    redirect = bus.branch_taken & ~bus.halt_req & ((state == RUN) | (state == HALT & bus.resume));
    take = redirect & ~misaligned;
    to_fault = redirect & misaligned;
    adv = state == RUN & ~bus.halt_req & ~bus.branch_taken & ~bus.stall;
    state_n = state == BOOT ? RUN :
              state == FAULT ? FAULT :
              bus.halt_req ? HALT :
              to_fault ? FAULT :
              state == HALT & ~bus.resume ? HALT : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc <= RESET_PC;
      cnt <= '0;
    end else begin
      state <= state_n;
      pc <= take ? tgt : adv ? pc + 32'd4 : pc;
      cnt <= cnt + COUNT_WIDTH'(take | adv);
    end
  end
  assign bus.pc = pc;
  assign bus.pc_plus4 = pc + 32'd4;
  assign bus.valid = state == RUN;
  assign bus.halted = state == HALT;
  assign bus.fetch_count = cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of reset, advance, stall, redirect, halt/resume, wrap and alignment
module tb_pc_sequencer;
  logic clk = 0, rst = 1, rst4 = 1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pc_sequencer_if #(.COUNT_WIDTH(16)) bus ();
  pc_sequencer_if #(.COUNT_WIDTH(4)) bus4 ();
  pc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  pc_sequencer #(.COUNT_WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic h, input logic r);
    bus.stall = s;
    bus.branch_taken = b;
    bus.branch_target = t;
    bus.halt_req = h;
    bus.resume = r;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0);
    bus4.stall = 0;
    bus4.branch_taken = 0;
    bus4.branch_target = 0;
    bus4.halt_req = 0;
    bus4.resume = 0;
    step(2);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_pc4", bus.pc_plus4, 32'h4);
    check("rst_valid", bus.valid, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_cnt", bus.fetch_count, 0);
    rst = 0;
    #1 check("boot_valid", bus.valid, 0);
    step;
    check("run_valid", bus.valid, 1);
    check("run_pc0", bus.pc, 32'h0);
    step; check("adv_4", bus.pc, 32'h4);
    step; check("adv_8", bus.pc, 32'h8);
    step; check("adv_c", bus.pc, 32'hc);
    step; check("adv_10", bus.pc, 32'h10);
    check("adv_cnt", bus.fetch_count, 4);
    drive(1, 0, 0, 0, 0); step;
    check("stall_pc", bus.pc, 32'h10);
    check("stall_cnt", bus.fetch_count, 4);
    drive(1, 1, 32'h40, 0, 0); step;
    check("stall_br_pc", bus.pc, 32'h40);
    check("stall_br_cnt", bus.fetch_count, 5);
    drive(1, 0, 0, 0, 0); step;
    check("stall_hold_pc", bus.pc, 32'h40);
    drive(0, 0, 0, 0, 0); step;
    check("post_stall_pc", bus.pc, 32'h44);
    drive(0, 0, 0, 1, 0); step;
    check("halt_halted", bus.halted, 1);
    check("halt_valid", bus.valid, 0);
    drive(0, 1, 32'h100, 0, 0); step;
    check("halt_br_ignored", bus.pc, 32'h44);
    drive(0, 0, 0, 0, 0); step(3);
    check("halt_frozen", bus.pc, 32'h44);
    check("halt_cnt", bus.fetch_count, 6);
    drive(0, 0, 0, 1, 1); step;
    check("halt_over_resume", bus.halted, 1);
    drive(0, 1, 32'h80, 0, 1); step;
    check("resume_valid", bus.valid, 1);
    check("resume_pc", bus.pc, 32'h80);
    check("resume_cnt", bus.fetch_count, 7);
    drive(0, 0, 0, 0, 0); step;
    check("resume_adv", bus.pc, 32'h84);
    drive(0, 1, 32'hffff_fff8, 0, 0); step;
    check("wrap_load", bus.pc, 32'hffff_fff8);
    drive(0, 0, 0, 0, 0); step;
    check("wrap_fffc", bus.pc, 32'hffff_fffc);
    check("wrap_pc4", bus.pc_plus4, 32'h0);
    step;
    check("wrap_zero", bus.pc, 32'h0);
    check("wrap_cnt", bus.fetch_count, 11);
    drive(0, 1, 32'h300, 1, 0); step;
    check("prio_halted", bus.halted, 1);
    check("prio_pc", bus.pc, 32'h0);
    check("prio_cnt", bus.fetch_count, 11);
    drive(0, 1, 32'h200, 0, 1); step;
    drive(0, 0, 0, 1, 0); step;
    check("pre_rst_pc", bus.pc, 32'h200);
    check("pre_rst_halted", bus.halted, 1);
    drive(0, 0, 0, 0, 0);
    rst = 1; step; rst = 0;
    check("midrst_pc", bus.pc, 32'h0);
    check("midrst_halted", bus.halted, 0);
    check("midrst_valid", bus.valid, 0);
    check("midrst_cnt", bus.fetch_count, 0);
    step;
    check("midrst_run", bus.valid, 1);
    drive(0, 1, 32'h42, 0, 0); step;
`ifdef PC_ALIGN_CHECK_EN
    check("mis_fault", bus.fault, 1);
    check("mis_pc", bus.pc, 32'h0);
    check("mis_valid", bus.valid, 0);
    drive(0, 0, 0, 0, 1); step;
    check("mis_resume", bus.fault, 1);
    drive(0, 0, 0, 0, 0);
    rst = 1; step; rst = 0;
    check("mis_rst", bus.fault, 0);
`else
    check("mask_pc", bus.pc, 32'h40);
    check("mask_fault", bus.fault, 0);
    check("mask_cnt", bus.fetch_count, 1);
`endif
    drive(0, 0, 0, 0, 0);
    step;
    rst4 = 0;
    step;
    check("cw4_run", bus4.valid, 1);
    step(17);
    check("cw4_wrap", bus4.fetch_count, 1);
    check("cw4_pc", bus4.pc, 32'h44);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
